// File: rtl/or_gate_checker.sv
// Exhaustive stimulus/response self-test for an N_IN-input OR gate: sweeps all input vectors,
// compares the gate output with the OR reduction and reports a saturating error count.
// Optional first-failure capture ports are enabled by defining ORCHK_FAILCAP_EN.
module or_gate_checker #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic             in_resp,
    output logic [N_IN-1:0]  out_stim,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_pass,
    output logic [ERR_W-1:0] out_err_cnt,
`ifdef ORCHK_FAILCAP_EN
    output logic             out_fail_vld,
    output logic [N_IN-1:0]  out_fail_vec,
    output logic             out_fail_resp,
`endif
    output logic [N_IN-1:0]  out_vec_idx
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state;
    logic [N_IN-1:0]  idx;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        mismatch     = 1'b0;
        err_cnt_next = out_err_cnt;
        if (state == ST_CHECK) begin
            mismatch = (in_resp != (|out_stim));
            if (mismatch && !(&out_err_cnt))
                err_cnt_next = out_err_cnt + ERR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            cnt           <= '0;
            out_stim      <= '0;
            out_busy      <= 1'b0;
            out_done      <= 1'b0;
            out_pass      <= 1'b0;
            out_err_cnt   <= '0;
            out_vec_idx   <= '0;
`ifdef ORCHK_FAILCAP_EN
            out_fail_vld  <= 1'b0;
            out_fail_vec  <= '0;
            out_fail_resp <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (in_start) begin
                        out_err_cnt   <= '0;
                        out_done      <= 1'b0;
                        out_pass      <= 1'b0;
                        out_busy      <= 1'b1;
                        idx           <= '0;
                        state         <= ST_DRIVE;
`ifdef ORCHK_FAILCAP_EN
                        out_fail_vld  <= 1'b0;
                        out_fail_vec  <= '0;
                        out_fail_resp <= 1'b0;
`endif
                    end
                end
                ST_DRIVE: begin
                    out_stim    <= idx;
                    out_vec_idx <= idx;
                    cnt         <= SETTLE_LOAD;
                    state       <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == '0)
                        state <= ST_CHECK;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                ST_CHECK: begin
                    out_err_cnt <= err_cnt_next;
`ifdef ORCHK_FAILCAP_EN
                    if (mismatch && !out_fail_vld) begin
                        out_fail_vld  <= 1'b1;
                        out_fail_vec  <= out_stim;
                        out_fail_resp <= in_resp;
                    end
`endif
                    // Last vector ends the sweep; the index never wraps back to zero mid-sweep.
                    if (idx == LAST_IDX) begin
                        out_busy <= 1'b0;
                        out_done <= 1'b1;
                        out_pass <= (err_cnt_next == '0);
                        out_stim <= '0;
                        state    <= ST_DONE;
                    end else begin
                        idx   <= idx + N_IN'(1);
                        state <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or_gate_checker.sv
// Self-checking bench for or_gate_checker: a table of directed sweeps plus random faulty-gate
// sweeps on a 2-input instance, and a saturation check on a 3-input, 2-bit-counter instance.
module tb_or_gate_checker;

    localparam int A_N = 2, A_S = 4, A_E = 8;
    localparam int B_N = 3, B_S = 2, B_E = 2;
    localparam int A_EDGES = (1 << A_N) * (A_S + 2);
    localparam int B_EDGES = (1 << B_N) * (B_S + 2);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start_a, resp_a;
    logic [A_N-1:0]   stim_a, vidx_a;
    logic             busy_a, done_a, pass_a;
    logic [A_E-1:0]   err_a;
    logic             start_b, resp_b;
    logic [B_N-1:0]   stim_b, vidx_b;
    logic             busy_b, done_b, pass_b;
    logic [B_E-1:0]   err_b;
`ifdef ORCHK_FAILCAP_EN
    logic             fvld_a, fresp_a, fvld_b, fresp_b;
    logic [A_N-1:0]   fvec_a;
    logic [B_N-1:0]   fvec_b;
`endif

    or_gate_checker #(.N_IN(A_N), .SETTLE_CYC(A_S), .ERR_W(A_E)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_start(start_a), .in_resp(resp_a),
        .out_stim(stim_a), .out_busy(busy_a), .out_done(done_a), .out_pass(pass_a),
        .out_err_cnt(err_a),
`ifdef ORCHK_FAILCAP_EN
        .out_fail_vld(fvld_a), .out_fail_vec(fvec_a), .out_fail_resp(fresp_a),
`endif
        .out_vec_idx(vidx_a)
    );

    or_gate_checker #(.N_IN(B_N), .SETTLE_CYC(B_S), .ERR_W(B_E)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_start(start_b), .in_resp(resp_b),
        .out_stim(stim_b), .out_busy(busy_b), .out_done(done_b), .out_pass(pass_b),
        .out_err_cnt(err_b),
`ifdef ORCHK_FAILCAP_EN
        .out_fail_vld(fvld_b), .out_fail_vec(fvec_b), .out_fail_resp(fresp_b),
`endif
        .out_vec_idx(vidx_b)
    );

    // Gate models: 0 ideal OR, 1 stuck-at-0, 2 AND, 3 OR with response flipped on masked vectors.
    int         mode_a;
    logic [3:0] mask_a;
    int         mode_b;
    always_comb begin
        case (mode_a)
            0:       resp_a = |stim_a;
            1:       resp_a = 1'b0;
            2:       resp_a = &stim_a;
            default: resp_a = (|stim_a) ^ mask_a[stim_a];
        endcase
        resp_b = (mode_b == 0) ? 1'b0 : ~(|stim_b);
    end

    typedef struct {
        int         mode;
        logic [3:0] mask;
        int         start_at;
        int         exp_err;
        bit         exp_pass;
        int         exp_fvec;
        bit         exp_fresp;
    } sweep_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected results of a masked sweep, counted vector by vector from the OR truth table.
    function automatic sweep_t model(input logic [3:0] mask);
        sweep_t r;
        r.mode = 3; r.mask = mask; r.start_at = 0;
        r.exp_err = 0; r.exp_fvec = 0; r.exp_fresp = 1'b0;
        for (int v = 3; v >= 0; v--) begin
            if (mask[v]) begin
                r.exp_err++;
                r.exp_fvec  = v;
                r.exp_fresp = !(v != 0);
            end
        end
        r.exp_pass = (r.exp_err == 0);
        return r;
    endfunction

    task automatic run_sweep(input sweep_t s, input string tag);
        int   k;
        int   exp_stim;
        bit   stim_bad;
        logic [31:0] bad_got, bad_exp;
        mode_a = s.mode;
        mask_a = s.mask;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check({tag, " busy_after_accept"}, {31'b0, busy_a}, 32'd1);
        check({tag, " done_cleared"}, {31'b0, done_a}, 32'd0);
        k = 0; stim_bad = 0; bad_got = 0; bad_exp = 0;
        while (!done_a && k < 4 * A_EDGES) begin
            @(posedge clk);
            #1;
            k++;
            exp_stim = (k < A_EDGES) ? (k - 1) / (A_S + 2) : 0;
            if (!stim_bad && stim_a != exp_stim[A_N-1:0]) begin
                stim_bad = 1; bad_got = 32'(stim_a); bad_exp = 32'(exp_stim);
            end
            start_a = (k == s.start_at);
        end
        start_a = 1'b0;
        check({tag, " stim_seq"}, bad_got, bad_exp);
        check({tag, " done_edge"}, k, A_EDGES);
        check({tag, " err_cnt"}, 32'(err_a), s.exp_err);
        check({tag, " pass"}, {31'b0, pass_a}, {31'b0, s.exp_pass});
        check({tag, " busy_end"}, {31'b0, busy_a}, 32'd0);
        check({tag, " vec_idx_end"}, 32'(vidx_a), 32'd3);
`ifdef ORCHK_FAILCAP_EN
        check({tag, " fail_vld"}, {31'b0, fvld_a}, {31'b0, s.exp_err != 0});
        if (s.exp_err != 0) begin
            check({tag, " fail_vec"}, 32'(fvec_a), s.exp_fvec);
            check({tag, " fail_resp"}, {31'b0, fresp_a}, {31'b0, s.exp_fresp});
        end
`endif
        @(posedge clk);
        #1;
        check({tag, " done_holds"}, {30'b0, busy_a, done_a}, 32'd1);
    endtask

    task automatic run_b(input int mode, input string tag);
        int k;
        mode_b = mode;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        k = 0;
        while (!done_b && k < 4 * B_EDGES) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " done_edge"}, k, B_EDGES);
        check({tag, " err_sat"}, 32'(err_b), 32'd3);
        check({tag, " pass"}, {31'b0, pass_b}, 32'd0);
        check({tag, " stim_end"}, 32'(stim_b), 32'd0);
    endtask

    sweep_t table_v[5];
    int     k;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        mode_a = 0; mask_a = '0; mode_b = 0;

        table_v[0] = '{mode: 0, mask: 4'h0, start_at: 0,  exp_err: 0, exp_pass: 1, exp_fvec: 0, exp_fresp: 0};
        table_v[1] = '{mode: 1, mask: 4'h0, start_at: 0,  exp_err: 3, exp_pass: 0, exp_fvec: 1, exp_fresp: 0};
        table_v[2] = '{mode: 2, mask: 4'h0, start_at: 0,  exp_err: 2, exp_pass: 0, exp_fvec: 1, exp_fresp: 0};
        table_v[3] = '{mode: 0, mask: 4'h0, start_at: 9,  exp_err: 0, exp_pass: 1, exp_fvec: 0, exp_fresp: 0};
        table_v[4] = '{mode: 1, mask: 4'h0, start_at: 23, exp_err: 3, exp_pass: 0, exp_fvec: 1, exp_fresp: 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {24'b0, stim_a, vidx_a, busy_a, done_a, pass_a, 1'b0}, 32'd0);
        check("reset err_cnt", 32'(err_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_sweep(table_v[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 6; i++)
            run_sweep(model(4'($urandom_range(15))), $sformatf("rnd%0d", i));

        // Reset during SETTLE of vector 2 aborts the sweep and clears the partial error count.
        mode_a = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (k = 0; k < 2 * (A_S + 2) + 3; k++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset err_cnt", 32'(err_a), 32'd1);
        check("pre_reset stim", 32'(stim_a), 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_reset busy", {31'b0, busy_a}, 32'd0);
        check("mid_reset stim", 32'(stim_a), 32'd0);
        check("mid_reset err_cnt", 32'(err_a), 32'd0);
        check("mid_reset done", {31'b0, done_a}, 32'd0);
        run_sweep(table_v[0], "post_reset");

        run_b(0, "sat_stuck0");
        run_b(1, "sat_invert");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
